// File: rtl/aes_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | aes_ctrl_pkg: shared constants, phase encoding and helpers for the AES   |
// | round controller.                                   Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

package aes_ctrl_pkg;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_RCON_POLY = 8'h1B;

  localparam int DEF_BYTES_PER_ROUND = 16;
  localparam int DEF_KS_CYCLES       = 4;
  localparam int DEF_MC_PERIOD       = 4;
  localparam int DEF_NUM_ROUNDS      = 10;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_BYTE      = 3'd1,
    PH_KEYSCHED  = 3'd2,
    PH_SHIFTROWS = 3'd3,
    PH_INVALID   = 3'd4
  } phase_e;

  function automatic int aes_round_len(input int bytes_per_round, input int ks_cycles);
    return bytes_per_round + ks_cycles + 1;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_ctrl_rounds_rcon.sv
// +--------------------------------------------------------------------------+
// | aes_rcon_gen: 8-bit AES round-constant register (load-init/advance/hold).|
// |                                                     Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_rcon_gen
  import aes_ctrl_pkg::*;
(
  input  logic       ClkxCI,
  input  logic       RstxBI,
  input  logic       LoadInitxSI,
  input  logic       AdvancexSI,
  output logic [7:0] RconxDO
);

  logic [7:0] rcon_q, rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (LoadInitxSI) begin
      rcon_d = AES_RCON_INIT;
    end else if (AdvancexSI) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      rcon_q <= AES_RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign RconxDO = rcon_q;

endmodule

`default_nettype wire

// File: rtl/aes_ctrl_rounds.sv
// +--------------------------------------------------------------------------+
// | aes_ctrl_rounds: round/phase controller for the byte-serial TI AES core. |
// | Optional AES_CTRL_ABORT_EN adds AbortxSI.           Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_ctrl_rounds
  import aes_ctrl_pkg::*;
#(
  parameter int BYTES_PER_ROUND = DEF_BYTES_PER_ROUND,
  parameter int KS_CYCLES       = DEF_KS_CYCLES,
  parameter int MC_PERIOD       = DEF_MC_PERIOD,
  parameter int NUM_ROUNDS      = DEF_NUM_ROUNDS
) (
  input  logic                               ClkxCI,
  input  logic                               RstxBI,
  input  logic                               StartxSI,
  input  logic                               StallxSI,
`ifdef AES_CTRL_ABORT_EN
  input  logic                               AbortxSI,
`endif
  output logic                               BusyxSO,
  output logic                               DonexSO,
  output logic                               CycleEnxSO,
  output logic [$clog2(BYTES_PER_ROUND)-1:0] ByteIdxxDO,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]    RoundxDO,
  output logic [7:0]                         RconxDO,
  output logic                               StateIDLExS,
  output logic                               FirstCyclexS,
  output logic                               ByteFirstxS,
  output logic                               ByteMidxS,
  output logic                               ByteLastxS,
  output logic                               KeySchedxS,
  output logic                               ShiftRowsxS,
  output logic                               doMixColumnsxS,
  output logic                               LastRoundxS
);

  localparam int RLEN = aes_round_len(BYTES_PER_ROUND, KS_CYCLES);
  localparam int CW   = $clog2(RLEN + 1);
  localparam int RW   = $clog2(NUM_ROUNDS + 1);
  localparam int BW   = $clog2(BYTES_PER_ROUND);

  localparam logic [CW-1:0] C_ONE        = CW'(1);
  localparam logic [CW-1:0] C_LEN        = CW'(RLEN);
  localparam logic [CW-1:0] C_BYTE_END   = CW'(BYTES_PER_ROUND);
  localparam logic [CW-1:0] C_KS_END     = CW'(BYTES_PER_ROUND + KS_CYCLES);
  localparam logic [CW-1:0] C_MC         = CW'(MC_PERIOD);
  localparam logic [CW-1:0] C_LAST_START = CW'(BYTES_PER_ROUND - MC_PERIOD + 1);
  localparam logic [RW-1:0] R_ONE        = RW'(1);
  localparam logic [RW-1:0] R_LAST       = RW'(NUM_ROUNDS);

  logic [CW-1:0] cnt_q, cnt_d, cnt_m1;
  logic [RW-1:0] round_q, round_d;
  logic          done_q, done_d;
  logic          rcon_init, rcon_adv;
  logic          AbortxS;
  phase_e        phase;

`ifdef AES_CTRL_ABORT_EN
  assign AbortxS = AbortxSI;
`else
  assign AbortxS = 1'b0;
`endif

  always_comb begin
    phase = PH_INVALID;
    if (cnt_q == '0) begin
      phase = PH_IDLE;
    end else if (cnt_q <= C_BYTE_END) begin
      phase = PH_BYTE;
    end else if (cnt_q <= C_KS_END) begin
      phase = PH_KEYSCHED;
    end else if (cnt_q == C_LEN) begin
      phase = PH_SHIFTROWS;
    end
  end

  // Abort outranks stall and the final-round wrap; out-of-range counts recover to IDLE.
  always_comb begin
    cnt_d     = cnt_q;
    round_d   = round_q;
    done_d    = 1'b0;
    rcon_init = 1'b0;
    rcon_adv  = 1'b0;
    if (phase == PH_IDLE) begin
      if (StartxSI && !AbortxS) begin
        cnt_d     = C_ONE;
        round_d   = R_ONE;
        rcon_init = 1'b1;
      end
    end else if (phase == PH_INVALID || AbortxS) begin
      cnt_d     = '0;
      round_d   = '0;
      rcon_init = 1'b1;
    end else if (!StallxSI) begin
      if (cnt_q != C_LEN) begin
        cnt_d = cnt_q + C_ONE;
      end else if (round_q == R_LAST) begin
        cnt_d     = '0;
        round_d   = '0;
        rcon_init = 1'b1;
        done_d    = 1'b1;
      end else begin
        cnt_d    = C_ONE;
        round_d  = round_q + R_ONE;
        rcon_adv = 1'b1;
      end
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      cnt_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  aes_rcon_gen u_rcon (
    .ClkxCI      (ClkxCI),
    .RstxBI      (RstxBI),
    .LoadInitxSI (rcon_init),
    .AdvancexSI  (rcon_adv),
    .RconxDO     (RconxDO)
  );

  assign cnt_m1         = cnt_q - C_ONE;
  assign StateIDLExS    = (phase == PH_IDLE);
  assign BusyxSO        = ~StateIDLExS;
  assign DonexSO        = done_q;
  assign CycleEnxSO     = BusyxSO & ~StallxSI;
  assign RoundxDO       = round_q;
  assign LastRoundxS    = (round_q == R_LAST);
  assign FirstCyclexS   = (cnt_q == C_ONE);
  assign ByteIdxxDO     = (phase == PH_BYTE) ? BW'(cnt_m1) : '0;
  assign ByteFirstxS    = (phase == PH_BYTE) && (cnt_q <= C_MC);
  assign ByteLastxS     = (phase == PH_BYTE) && (cnt_q >= C_LAST_START);
  assign ByteMidxS      = (phase == PH_BYTE) && !ByteFirstxS && !ByteLastxS;
  assign KeySchedxS     = (phase == PH_KEYSCHED);
  assign ShiftRowsxS    = (phase == PH_SHIFTROWS);
  assign doMixColumnsxS = (phase == PH_BYTE) && ((cnt_m1 % C_MC) == '0) && !LastRoundxS;

endmodule

`default_nettype wire

// File: tb/tb_aes_ctrl_rounds.sv
// +--------------------------------------------------------------------------+
// | tb_aes_ctrl_rounds: scoreboard bench for aes_ctrl_rounds (default and    |
// | 14-round configurations).                           Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_aes_ctrl_rounds;

  logic ClkxCI = 1'b0;
  logic RstxBI = 1'b0;
  logic StartxSI = 1'b0, StallxSI = 1'b0;
  logic StartBxS = 1'b0;
`ifdef AES_CTRL_ABORT_EN
  logic AbortxSI = 1'b0;
`endif

  logic       BusyxSO, DonexSO, CycleEnxSO, StateIDLExS, FirstCyclexS, ByteFirstxS, ByteMidxS;
  logic       ByteLastxS, KeySchedxS, ShiftRowsxS, doMixColumnsxS, LastRoundxS;
  logic [3:0] ByteIdxxDO, RoundxDO;
  logic [7:0] RconxDO;

  logic       BusyB, DoneB, CycleEnB, IdleB, FirstB, BFirstB, BMidB, BLastB, KsB, SrB, McB, LastB;
  logic [3:0] ByteIdxB, RoundB;
  logic [7:0] RconB;

  int checks = 0;
  int errors = 0;

  logic [7:0] RCON_TAB [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};
  logic [7:0] q_rcon [$];
  int         q_done [$];

  always #5 ClkxCI = ~ClkxCI;

  aes_ctrl_rounds dut (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .StartxSI(StartxSI), .StallxSI(StallxSI),
`ifdef AES_CTRL_ABORT_EN
    .AbortxSI(AbortxSI),
`endif
    .BusyxSO(BusyxSO), .DonexSO(DonexSO), .CycleEnxSO(CycleEnxSO), .ByteIdxxDO(ByteIdxxDO),
    .RoundxDO(RoundxDO), .RconxDO(RconxDO), .StateIDLExS(StateIDLExS), .FirstCyclexS(FirstCyclexS),
    .ByteFirstxS(ByteFirstxS), .ByteMidxS(ByteMidxS), .ByteLastxS(ByteLastxS),
    .KeySchedxS(KeySchedxS), .ShiftRowsxS(ShiftRowsxS), .doMixColumnsxS(doMixColumnsxS),
    .LastRoundxS(LastRoundxS)
  );

  aes_ctrl_rounds #(.BYTES_PER_ROUND(16), .KS_CYCLES(8), .MC_PERIOD(4), .NUM_ROUNDS(14)) dut14 (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .StartxSI(StartBxS), .StallxSI(1'b0),
`ifdef AES_CTRL_ABORT_EN
    .AbortxSI(1'b0),
`endif
    .BusyxSO(BusyB), .DonexSO(DoneB), .CycleEnxSO(CycleEnB), .ByteIdxxDO(ByteIdxB),
    .RoundxDO(RoundB), .RconxDO(RconB), .StateIDLExS(IdleB), .FirstCyclexS(FirstB),
    .ByteFirstxS(BFirstB), .ByteMidxS(BMidB), .ByteLastxS(BLastB),
    .KeySchedxS(KsB), .ShiftRowsxS(SrB), .doMixColumnsxS(McB), .LastRoundxS(LastB)
  );

  task automatic tick();
    @(posedge ClkxCI);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (StateIDLExS !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", StateIDLExS); end
    checks++; if (BusyxSO !== 1'b0 || DonexSO !== 1'b0 || CycleEnxSO !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b%b want 000", BusyxSO, DonexSO, CycleEnxSO); end
    checks++; if (RoundxDO !== 4'd0 || ByteIdxxDO !== 4'd0) begin errors++; $display("FAIL reset_round got %0d/%0d want 0/0", RoundxDO, ByteIdxxDO); end
    checks++; if (RconxDO !== 8'h01) begin errors++; $display("FAIL reset_rcon got %h want 01", RconxDO); end
    checks++; if ({FirstCyclexS, ByteFirstxS, ByteMidxS, ByteLastxS, KeySchedxS, ShiftRowsxS, doMixColumnsxS, LastRoundxS} !== 8'h00) begin
      errors++; $display("FAIL reset_strobes got %b want 00000000", {FirstCyclexS, ByteFirstxS, ByteMidxS, ByteLastxS, KeySchedxS, ShiftRowsxS, doMixColumnsxS, LastRoundxS});
    end
    RstxBI = 1'b1;
    StallxSI = 1'b1;
    repeat (2) tick();
    StallxSI = 1'b0;
    checks++; if (StateIDLExS !== 1'b1 || DonexSO !== 1'b0) begin errors++; $display("FAIL idle_hold got idle=%b done=%b want 1/0", StateIDLExS, DonexSO); end
  endtask

  // Runs one default encryption; optional stall of stall_len cycles at round 2, C=7.
  task automatic run_encrypt(input int stall_len, input int exp_done);
    int  mc, mr, stalled;
    bit  stall, exp_mc;
    logic [7:0] er;
    q_done.push_back(exp_done);
    for (int i = 0; i < 10; i++) q_rcon.push_back(RCON_TAB[i]);
    StartxSI = 1'b1;
    tick();
    StartxSI = 1'b0;
    mc = 1; mr = 1; stalled = 0;
    for (int rel = 1; rel <= 300; rel++) begin
      stall = (stall_len > 0) && (mr == 2) && (mc == 7) && (stalled < stall_len);
      StallxSI = stall;
      #1;
      exp_mc = (mr != 0) && (mc <= 16) && (((mc - 1) % 4) == 0) && (mr != 10);
      checks++; if (doMixColumnsxS !== exp_mc) begin errors++; $display("FAIL mixcol rel=%0d got %b want %b", rel, doMixColumnsxS, exp_mc); end
      checks++; if (BusyxSO !== (mr != 0)) begin errors++; $display("FAIL busy rel=%0d got %b want %b", rel, BusyxSO, mr != 0); end
      checks++; if (LastRoundxS !== (mr == 10)) begin errors++; $display("FAIL lastround rel=%0d got %b want %b", rel, LastRoundxS, mr == 10); end
      checks++; if (CycleEnxSO !== (mr != 0 && !stall)) begin errors++; $display("FAIL cycle_en rel=%0d got %b want %b", rel, CycleEnxSO, mr != 0 && !stall); end
      checks++; if (FirstCyclexS !== (mr != 0 && mc == 1)) begin errors++; $display("FAIL first_cycle rel=%0d got %b want %b", rel, FirstCyclexS, mr != 0 && mc == 1); end
      if (stall) begin
        checks++; if (ByteIdxxDO !== 4'd6) begin errors++; $display("FAIL stall_hold rel=%0d got %0d want 6", rel, ByteIdxxDO); end
      end
      if (FirstCyclexS) begin
        checks++;
        if (q_rcon.size() == 0) begin errors++; $display("FAIL rcon_extra rel=%0d got %h want none", rel, RconxDO); end
        else begin
          er = q_rcon.pop_front();
          if (RconxDO !== er || RoundxDO !== 4'(mr)) begin errors++; $display("FAIL rcon rel=%0d got %h/r%0d want %h/r%0d", rel, RconxDO, RoundxDO, er, mr); end
        end
      end
      if (DonexSO) begin
        checks++;
        if (q_done.size() == 0) begin errors++; $display("FAIL done_extra got rel=%0d want none", rel); end
        else if (q_done[0] != rel) begin errors++; $display("FAIL done_cycle got %0d want %0d", rel, q_done.pop_front()); end
        else void'(q_done.pop_front());
      end
      if (mr == 0) break;
      tick();
      if (stall) stalled++;
      else begin
        mc++;
        if (mc > 21) begin mc = 1; mr = (mr == 10) ? 0 : mr + 1; end
      end
    end
    StallxSI = 1'b0;
    checks++; if (q_done.size() != 0 || q_rcon.size() != 0) begin errors++; $display("FAIL sb_drain got done=%0d rcon=%0d want 0/0", q_done.size(), q_rcon.size()); end
    q_done.delete(); q_rcon.delete();
    tick();
    checks++; if (DonexSO !== 1'b0 || StateIDLExS !== 1'b1) begin errors++; $display("FAIL done_pulse_len got done=%b idle=%b want 0/1", DonexSO, StateIDLExS); end
  endtask

  task automatic test_full_run();
    run_encrypt(0, 211);
  endtask

  task automatic test_stall();
    run_encrypt(3, 214);
  endtask

  task automatic test_rounds14();
    int busy = 0;
    bit seen = 0;
    logic [7:0] er;
    for (int i = 0; i < 14; i++) q_rcon.push_back(RCON_TAB[i]);
    q_done.push_back(351);
    StartBxS = 1'b1;
    tick();
    for (int rel = 1; rel <= 400; rel++) begin
      if (BusyB) busy++;
      if (FirstB) begin
        checks++;
        if (q_rcon.size() == 0) begin errors++; $display("FAIL r14_rcon_extra got %h want none", RconB); end
        else begin er = q_rcon.pop_front(); if (RconB !== er) begin errors++; $display("FAIL r14_rcon got %h want %h", RconB, er); end end
      end
      if (DoneB) begin
        checks++;
        if (q_done.pop_front() != rel) begin errors++; $display("FAIL r14_done_cycle got %0d want 351", rel); end
        checks++; if (BusyB !== 1'b0 || RconB !== 8'h01 || RoundB !== 4'd0) begin errors++; $display("FAIL r14_done_idle got b=%b r=%h n=%0d want 0/01/0", BusyB, RconB, RoundB); end
        seen = 1;
        break;
      end
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL r14_timeout got no done want done"); end
    checks++; if (busy != 350) begin errors++; $display("FAIL r14_busy got %0d want 350", busy); end
    checks++; if (q_rcon.size() != 0) begin errors++; $display("FAIL r14_rcon_left got %0d want 0", q_rcon.size()); end
    q_rcon.delete(); q_done.delete();
    tick();
    StartBxS = 1'b0;
    checks++; if (RoundB !== 4'd1 || RconB !== 8'h01 || FirstB !== 1'b1) begin errors++; $display("FAIL r14_restart got r%0d %h f=%b want r1 01 1", RoundB, RconB, FirstB); end
  endtask

  task automatic test_async_reset();
    StartxSI = 1'b1;
    tick();
    StartxSI = 1'b0;
    repeat (101) tick();
    checks++; if (RoundxDO !== 4'd5 || KeySchedxS !== 1'b1) begin errors++; $display("FAIL pre_reset got r%0d ks=%b want r5 1", RoundxDO, KeySchedxS); end
    #2 RstxBI = 1'b0;
    #1;
    checks++; if (StateIDLExS !== 1'b1 || BusyxSO !== 1'b0 || RoundxDO !== 4'd0 || RconxDO !== 8'h01 || KeySchedxS !== 1'b0) begin
      errors++; $display("FAIL async_reset got idle=%b busy=%b r%0d %h ks=%b want 1/0/r0/01/0", StateIDLExS, BusyxSO, RoundxDO, RconxDO, KeySchedxS);
    end
    checks++; if (IdleB !== 1'b1) begin errors++; $display("FAIL async_reset14 got %b want 1", IdleB); end
    repeat (2) tick();
    #2 RstxBI = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (DonexSO !== 1'b0 || StateIDLExS !== 1'b1) begin errors++; $display("FAIL post_reset got done=%b idle=%b want 0/1", DonexSO, StateIDLExS); end
    end
  endtask

`ifdef AES_CTRL_ABORT_EN
  task automatic test_abort();
    StartxSI = 1'b1;
    tick();
    StartxSI = 1'b0;
    repeat (43) tick();
    checks++; if (RoundxDO !== 4'd3 || ByteIdxxDO !== 4'd1) begin errors++; $display("FAIL pre_abort got r%0d b%0d want r3 b1", RoundxDO, ByteIdxxDO); end
    AbortxSI = 1'b1; StallxSI = 1'b1;
    tick();
    AbortxSI = 1'b0; StallxSI = 1'b0;
    checks++; if (StateIDLExS !== 1'b1 || RoundxDO !== 4'd0 || RconxDO !== 8'h01 || DonexSO !== 1'b0) begin
      errors++; $display("FAIL abort got idle=%b r%0d %h done=%b want 1/r0/01/0", StateIDLExS, RoundxDO, RconxDO, DonexSO);
    end
    repeat (2) begin
      tick();
      checks++; if (DonexSO !== 1'b0) begin errors++; $display("FAIL abort_nodone got %b want 0", DonexSO); end
    end
    StartxSI = 1'b1; AbortxSI = 1'b1;
    tick();
    StartxSI = 1'b0; AbortxSI = 1'b0;
    checks++; if (StateIDLExS !== 1'b1) begin errors++; $display("FAIL abort_idle_start got %b want 1", StateIDLExS); end
    StartxSI = 1'b1;
    tick();
    StartxSI = 1'b0;
    checks++; if (RoundxDO !== 4'd1 || RconxDO !== 8'h01 || FirstCyclexS !== 1'b1) begin errors++; $display("FAIL abort_restart got r%0d %h f=%b want r1 01 1", RoundxDO, RconxDO, FirstCyclexS); end
    #2 RstxBI = 1'b0;
    #2 RstxBI = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #12;
    test_reset();
    test_full_run();
    test_stall();
    test_rounds14();
    test_async_reset();
`ifdef AES_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes_ctrl_rounds.md
Name: aes_ctrl_rounds

Overview:
- Parametrised round controller for the byte-serial threshold-implementation AES core.
- Generates the per-cycle phase strobes: key addition/S-box byte slots, key schedule, ShiftRows, MixColumns.
- Owns the round counter and Rcon generation internally, so the datapath no longer supplies a last-round flag.
- Adds a stall input so the core can wait on fresh-randomness availability, plus a start/busy/done handshake.

Parameters:
- BYTES_PER_ROUND, 16, byte-serial S-box/key-add cycles per round (multiple of MC_PERIOD)
- KS_CYCLES, 4, key-schedule cycles per round
- MC_PERIOD, 4, MixColumns strobe period within the byte phase
- NUM_ROUNDS, 10, rounds per encryption (10/12/14)

Ports:
- ClkxCI  in  1  clock, rising edge
- RstxBI  in  1  reset, asynchronous, active-low
- StartxSI  in  1  start request, sampled only in IDLE
- StallxSI  in  1  freeze controller this cycle
- BusyxSO  out  1  encryption in progress
- DonexSO  out  1  one-cycle completion pulse
- CycleEnxSO  out  1  datapath advance enable = BusyxSO & ~StallxSI
- ByteIdxxDO  out  clog2(BYTES_PER_ROUND)  current byte slot during byte phase, else 0
- RoundxDO  out  clog2(NUM_ROUNDS+1)  current round, 1..NUM_ROUNDS, 0 in IDLE
- RconxDO  out  8  current round constant
- StateIDLExS  out  1  idle
- FirstCyclexS  out  1  first byte cycle of any round
- ByteFirstxS  out  1  byte-phase cycles 1..MC_PERIOD
- ByteMidxS  out  1  byte-phase middle cycles
- ByteLastxS  out  1  final MC_PERIOD byte cycles
- KeySchedxS  out  1  key-schedule phase
- ShiftRowsxS  out  1  ShiftRows cycle
- doMixColumnsxS  out  1  MixColumns strobe
- LastRoundxS  out  1  RoundxDO == NUM_ROUNDS

Behaviour:
- Round length L = BYTES_PER_ROUND + KS_CYCLES + 1.
- Registered cycle counter C:
  - 0 = IDLE.
  - 1..BYTES_PER_ROUND = byte phase.
  - next KS_CYCLES = key schedule.
  - C = L = ShiftRows.
- Reset (async): C=0, round=0, Rcon=0x01, DonexSO=0. All strobes decode to IDLE: StateIDLExS=1, everything else 0.
- All strobes are combinational decodes of the registered C and round, with no extra latency.
- IDLE, StartxSI=1: next cycle C=1, round=1, Rcon=0x01. StartxSI is ignored when C≠0.
- StallxSI=1: C, round, Rcon hold; strobes stay decoded; CycleEnxSO=0. StallxSI in IDLE has no effect.
- C<L: C increments when not stalled.
- C=L, round<NUM_ROUNDS: C←1, round+1, Rcon←xtime(Rcon), i.e. Rcon<<1 ^ (Rcon[7] ? 0x1B : 0).
- C=L, round=NUM_ROUNDS: C←0, round←0, Rcon←0x01. DonexSO=1 for exactly the following cycle; it is registered.
- doMixColumnsxS=1 when C in byte phase, (C-1) mod MC_PERIOD == 0, and ~LastRoundxS.
- FirstCyclexS=1 iff C==1.
- Start and Done coincidence: a start in the Done cycle is accepted; that cycle is IDLE.
- Any C value outside 0..L transitions to 0 (recovery).

Optional Feature:
- Macro AES_CTRL_ABORT_EN.
- Defined: adds input AbortxSI (1 bit).
  - Abort while Busy: next cycle forces IDLE (C=0, round=0, Rcon=0x01) with no DonexSO pulse.
  - Abort has priority over StallxSI and over the final-round transition.
  - Abort in IDLE has no effect, and StartxSI is ignored that cycle.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package aes_ctrl_pkg holds:
  - AES_RCON_INIT = 8'h01 and AES_RCON_POLY = 8'h1B.
  - A function for the round length.
  - A function xtime.
  - Default parameter constants.
- One natural sub-module, aes_rcon_gen: 8-bit Rcon register with load-init / advance / hold controls.

Test Plan:
- Default params, StartxSI pulse sampled at edge 0, no stall:
  - BusyxSO high for 210 cycles.
  - DonexSO at cycle 211.
  - RconxDO sequence 01,02,04,08,10,20,40,80,1B,36.
- Round 1: doMixColumnsxS high exactly at C=1,5,9,13. In round 10 it is never high; LastRoundxS=1 throughout round 10.
- StallxSI held 3 cycles at round 2, C=7:
  - C stays 7 and CycleEnxSO=0 for those cycles.
  - Completion is delayed to cycle 214.
- Assert RstxBI low mid round 5, C=18: outputs are immediately IDLE, RconxDO=01, no DonexSO pulse.
- NUM_ROUNDS=14, KS_CYCLES=8: total busy = 14*25 = 350 cycles, final Rcon 0x4D. StartxSI held high is ignored while busy; restart happens in the Done cycle.
- AES_CTRL_ABORT_EN: AbortxSI at round 3, C=2 gives IDLE next cycle with no DonexSO. A subsequent start restarts at round 1 with Rcon=01.
